// File: rtl/mem_arb_pkg.sv
// Purpose: shared size codes, FSM state encoding and grant encoding for the memory port arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_DATA  = 1'b0,
    GNT_FETCH = 1'b1
  } gnt_t;

  // Beats per access; the reserved encoding 2'b11 behaves as a word, matching funct3[1:0].
  function automatic logic [2:0] size_to_beats(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_to_beats = 3'd1;
      SZ_HALF: size_to_beats = 3'd2;
      SZ_WORD: size_to_beats = 3'd4;
      default: size_to_beats = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch, load/store and byte-memory signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req and their request fields until the matching valid pulse.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_valid;
  logic [31:0]       d_rdata;

  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [7:0]        m_wdata;
  logic [7:0]        m_rdata;

  logic              busy;

  // Arbiter side: serves both requesters and drives the memory.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
    output if_valid, if_rdata, d_valid, d_rdata, m_addr, m_we, m_wdata, busy
  );

  // Environment side: requesters plus the memory array.
  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
    input  if_valid, if_rdata, d_valid, d_rdata, m_addr, m_we, m_wdata, busy
  );
endinterface

// File: rtl/mem_arb_beat_gen.sv
// Purpose: beat counter and byte-address generator for one serialized transfer.
// Latency: m_addr/last are combinational from the registered beat index.
// Backpressure: none; advances whenever step is high, restarts on start.
module mem_arb_beat_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [2:0]        count,
  output logic [ADDR_W-1:0] m_addr,
  output logic              last,
  output logic [1:0]        beat
);

  assign last   = ({1'b0, beat} == (count - 3'd1));
  // Address arithmetic wraps naturally at the top of the byte space.
  assign m_addr = base + ADDR_W'(beat);

  // Beat index: cleared on a new grant, advanced once per transfer cycle, back to 0 after the last beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat <= 2'd0;
    end else if (start) begin
      beat <= 2'd0;
    end else if (step) begin
      beat <= last ? 2'd0 : beat + 2'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one byte-wide memory between fetch and load/store, serializing 1/2/4 beats MSB-first (big-endian).
// Latency: request seen in IDLE at cycle 0, beats at cycles 1..N, valid pulse at N+1, next request sampled at N+2.
// Backpressure: requesters hold req until their valid; define MEM_ARB_RR_EN for round-robin instead of data-first priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  state_t            state, state_nxt;
  gnt_t              gnt_q;
  logic [ADDR_W-1:0] base_q;
  logic              we_q;
  logic [2:0]        count_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [31:0]       asm_nxt;
  logic [31:0]       if_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              any_req;
  logic              pick_data;
  logic              start;
  logic              step;
  logic              last;
  logic [1:0]        beat;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] beat_addr;

  assign any_req = bus.d_req | bus.if_req;
  assign start   = (state == IDLE) && any_req;
  assign step    = (state == XFER);
  assign asm_nxt = {asm_q[23:0], bus.m_rdata};
  // First beat carries the most significant used byte of the store data.
  assign lane    = 2'(count_q - 3'd1 - {1'b0, beat});

`ifdef MEM_ARB_RR_EN
  gnt_t prio_q;

  assign pick_data = bus.d_req && (!bus.if_req || (prio_q == GNT_DATA));

  // Priority flips to the other requester after every grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q <= GNT_DATA;
    end else if (start) begin
      prio_q <= pick_data ? GNT_FETCH : GNT_DATA;
    end
  end
`else
  assign pick_data = bus.d_req;
`endif

  mem_arb_beat_gen #(.ADDR_W(ADDR_W)) u_beat_gen (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .step   (step),
    .base   (base_q),
    .count  (count_q),
    .m_addr (beat_addr),
    .last   (last),
    .beat   (beat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus memory strobes, busy and the one-cycle valid pulses.
  always_comb begin
    state_nxt    = state;
    bus.m_addr   = '0;
    bus.m_we     = 1'b0;
    bus.m_wdata  = 8'h00;
    bus.busy     = 1'b0;
    bus.if_valid = 1'b0;
    bus.d_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = XFER;
      end
      XFER: begin
        bus.busy   = 1'b1;
        bus.m_addr = beat_addr;
        if (we_q) begin
          bus.m_we    = 1'b1;
          bus.m_wdata = wdata_q[{lane, 3'b000} +: 8];
        end
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.busy     = 1'b1;
        bus.if_valid = (gnt_q == GNT_FETCH);
        bus.d_valid  = (gnt_q == GNT_DATA);
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winning request so the transfer no longer depends on the live inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q   <= GNT_DATA;
      base_q  <= '0;
      we_q    <= 1'b0;
      count_q <= 3'd0;
      wdata_q <= '0;
    end else if (start) begin
      if (pick_data) begin
        gnt_q   <= GNT_DATA;
        base_q  <= bus.d_addr;
        we_q    <= bus.d_we;
        count_q <= size_to_beats(bus.d_size);
        wdata_q <= bus.d_wdata;
      end else begin
        gnt_q   <= GNT_FETCH;
        base_q  <= bus.if_addr;
        we_q    <= 1'b0;
        count_q <= 3'd4;
        wdata_q <= '0;
      end
    end
  end

  // Shift read bytes in MSB-first; on the last beat publish the word to the granted requester.
  always_ff @(posedge clk) begin
    if (!rst) begin
      asm_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (start) begin
      asm_q <= '0;
    end else if ((state == XFER) && !we_q) begin
      asm_q <= asm_nxt;
      if (last) begin
        if (gnt_q == GNT_FETCH) if_rdata_q <= asm_nxt;
        else                    d_rdata_q  <= asm_nxt;
      end
    end
  end

  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: scoreboard bench for mem_port_arbiter with a byte-array memory model and a reference memory image.
// Latency: expected valid latency is stored per request and compared when the pulse appears.
// Backpressure: drivers hold req until valid, then release it on that same cycle.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Memory array driven by the DUT, plus a backdoor write port for preloading.
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       pre_we   = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_dat  = 8'h00;

  always @(posedge clk) begin
    if (pre_we)        mem[pre_addr]   <= pre_dat;
    else if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
  end
  assign bus.m_rdata = mem[bus.m_addr];

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q_if[$];
  exp_t q_d[$];
  int   gnt_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string name);
    logic [83:0] v;
    v = {bus.if_valid, bus.if_rdata, bus.d_valid, bus.d_rdata,
         bus.m_addr, bus.m_we, bus.m_wdata, bus.busy};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL %s: outputs %h want all zero (cycle %0d)", name, v, cyc);
    end
  endtask

  task automatic chk_mem(input string name);
    int d = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) d++;
    check(name, 32'(d), 32'd0);
  endtask

  // Reference model: plain big-endian byte gathering/scattering over the memory image.
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [7:0] a, input int n);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < n; i++) r = (r << 8) | 32'(ref_mem[a + 8'(i)]);
    return r;
  endfunction

  task automatic ref_write(input logic [7:0] a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) ref_mem[a + 8'(i)] = wd[8*(n-1-i) +: 8];
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_dat  = d;
    pre_we   = 1'b1;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_valid(input bit data);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(data ? bus.d_valid : bus.if_valid) && n < 200);
    if (!(data ? bus.d_valid : bus.if_valid)) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no valid within 200 cycles", data ? "d" : "if");
    end
    if (data) bus.d_req = 1'b0;
    else      bus.if_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [7:0] a, input int lat);
    exp_t e;
    e.rdata = ref_read(a, 4);
    e.chk   = 1'b1;
    e.lat   = lat;
    e.t0    = cyc;
    q_if.push_back(e);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    wait_valid(1'b0);
  endtask

  task automatic do_data(input logic we, input logic [1:0] size, input logic [7:0] a,
                         input logic [31:0] wd, input int lat);
    exp_t e;
    int   n;
    n       = nbytes(size);
    e.chk   = !we;
    e.rdata = 32'd0;
    e.lat   = lat;
    e.t0    = cyc;
    if (we) ref_write(a, n, wd);
    else    e.rdata = ref_read(a, n);
    q_d.push_back(e);
    bus.d_we    = we;
    bus.d_size  = size;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_req   = 1'b1;
    wait_valid(1'b1);
  endtask

  // Checks a 1-bit output over a window of cycles relative to the current one.
  task automatic chk_window(input bit use_we, input string name, input int lo, input int hi, input int len);
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      check(name, 32'(use_we ? bus.m_we : bus.busy), ((k >= lo) && (k <= hi)) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic rand_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      do_fetch(8'($urandom_range(0, 124)), -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic rand_data(input int n);
    logic       we;
    logic [1:0] sz;
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = we ? 8'($urandom_range(128, 252)) : 8'($urandom_range(0, 255));
      do_data(we, sz, a, $urandom(), -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Monitor: pops the scoreboard whenever a valid pulse is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.if_valid || bus.d_valid) check("single_valid", 32'(bus.if_valid & bus.d_valid), 32'd0);
      if (bus.if_valid) begin
        gnt_log.push_back(1);
        check("if_expected", 32'(q_if.size() > 0), 32'd1);
        if (q_if.size() > 0) begin
          e = q_if.pop_front();
          if (e.chk) check("if_rdata", bus.if_rdata, e.rdata);
          if (e.lat >= 0) check("if_latency", 32'(cyc - e.t0), 32'(e.lat));
        end
      end
      if (bus.d_valid) begin
        gnt_log.push_back(0);
        check("d_expected", 32'(q_d.size() > 0), 32'd1);
        if (q_d.size() > 0) begin
          e = q_d.pop_front();
          if (e.chk) check("d_rdata", bus.d_rdata, e.rdata);
          if (e.lat >= 0) check("d_latency", 32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t       e;
    int         seen;
    logic [3:0] order;
    logic [3:0] want;

    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_size  = 2'b00;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom_range(0, 255)));
    poke(8'd0, 8'h00);
    poke(8'd1, 8'h00);
    poke(8'd2, 8'h20);
    poke(8'd3, 8'h83);
    chk_zero("reset_state");
    rst = 1'b1;
    @(negedge clk);
    chk_zero("idle_after_reset");

    // Fetch word at 0: busy over cycles 1..5, valid at 5.
    fork
      do_fetch(8'h00, 5);
      chk_window(1'b0, "fetch_busy", 1, 5, 7);
    join
    check("fetch_word", bus.if_rdata, 32'h00002083);

    // Store word at 12 then load half at 13.
    fork
      do_data(1'b1, SZ_WORD, 8'd12, 32'h11223344, 5);
      chk_window(1'b1, "store_we", 1, 4, 7);
    join
    check("store_bytes", {mem[12], mem[13], mem[14], mem[15]}, 32'h11223344);
    do_data(1'b0, SZ_HALF, 8'd13, 32'd0, 3);
    check("load_half", bus.d_rdata, 32'h00002233);
    check("if_rdata_hold", bus.if_rdata, 32'h00002083);
    @(negedge clk);

    // Address wrap at the top of memory.
    poke(8'hFF, 8'hAB);
    poke(8'h00, 8'hCD);
    do_data(1'b0, SZ_HALF, 8'hFF, 32'd0, 3);
    check("wrap_half", bus.d_rdata, 32'h0000ABCD);
    @(negedge clk);
    do_data(1'b0, SZ_BYTE, 8'hFF, 32'd0, 2);
    check("wrap_byte", bus.d_rdata, 32'h000000AB);
    @(negedge clk);
    do_data(1'b0, 2'b11, 8'hFE, 32'd0, 5);
    @(negedge clk);

    // Reset lands on the edge closing beat 2 of a word store.
    bus.d_we    = 1'b1;
    bus.d_size  = SZ_WORD;
    bus.d_addr  = 8'd12;
    bus.d_wdata = 32'hDEADBEEF;
    bus.d_req   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    chk_zero("abort_outputs");
    rst  = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen += int'(bus.d_valid);
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    ref_mem[12] = 8'hDE;
    ref_mem[13] = 8'hAD;
    check("abort_bytes", {mem[12], mem[13], mem[14], mem[15]}, 32'hDEAD3344);
    chk_mem("abort_mem");

    // Simultaneous requests right after reset: data first, fetch follows.
    fork
      do_data(1'b0, SZ_WORD, 8'h20, 32'd0, 5);
      do_fetch(8'h04, 11);
    join
    @(negedge clk);

    // Both requesters held continuously: grant order depends on the arbitration mode.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    gnt_log.delete();
    fork
      begin
        do_data(1'b0, SZ_WORD, 8'h10, 32'd0, -1);
        do_data(1'b0, SZ_BYTE, 8'h21, 32'd0, -1);
      end
      begin
        do_fetch(8'h30, -1);
        do_fetch(8'h34, -1);
      end
    join
    @(negedge clk);
    check("grant_count", 32'(gnt_log.size()), 32'd4);
    order = 4'd0;
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) order = {order[2:0], 1'(gnt_log[i])};
`ifdef MEM_ARB_RR_EN
    want = 4'b0101;
`else
    want = 4'b0011;
`endif
    check("grant_order", 32'(order), 32'(want));

    // Request pending while reset is held low.
    rst         = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_size  = SZ_WORD;
    bus.d_addr  = 8'h40;
    bus.d_wdata = 32'd0;
    bus.d_req   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_zero("rst_hold");
    end
    e.rdata = ref_read(8'h40, 4);
    e.chk   = 1'b1;
    e.lat   = 5;
    e.t0    = cyc;
    q_d.push_back(e);
    rst = 1'b1;
    wait_valid(1'b1);
    @(negedge clk);

    // Randomized concurrent traffic; stores stay out of the fetch region.
    fork
      rand_fetch(60);
      rand_data(80);
    join
    repeat (3) @(negedge clk);
    chk_mem("final_mem");
    check("if_queue_empty", 32'(q_if.size()), 32'd0);
    check("d_queue_empty", 32'(q_d.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
